// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: func3 codes, FSM states, access size decode and MEM/WB record.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic        bus_err;
  } memwb_t;

  // Reserved func3 codes fall through to word accesses.
  function automatic size_e f3_size(input logic [2:0] f3, input logic store);
    size_e sz;
    sz = SZ_W;
    if (store) begin
      case (f3)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_wb_stage_ls_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
module ls_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic        store,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  size_e       size;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign size   = f3_size(func3, store);
  assign lane_b = rdata[{addr, 3'b000} +: 8];
  assign lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'hF;
    wdata      = rs2;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        if (store) be = 4'b0001 << addr;
        wdata = {4{rs2[7:0]}};
      end
      SZ_H: begin
        misaligned = addr[0];
        if (store) be = 4'b0011 << addr;
        wdata = {2{rs2[15:0]}};
      end
      default: misaligned = (addr != 2'b00);
    endcase
  end

  always_comb begin
    load_ext = rdata;
    case (func3)
      F3_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  load_ext = {24'h0, lane_b};
      F3_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  load_ext = {16'h0, lane_h};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with req/ack data-memory FSM, wait-state timeout, branch resolve and MEM/WB register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        res,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic        zero_in,
  input  logic [31:0] pc_in,
  input  logic [2:0]  func3_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] reg2_data_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        PCSrc_out,
  output logic [31:0] branch_tgt_out,
  output logic        RegWrite_out,
  output logic [4:0]  rd_out,
  output logic [31:0] wb_data_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             req_raw, timeout, memop, misaligned, mis_drop;
  logic [31:0]      load_ext;
  memwb_t           memwb, memwb_n;

  assign memop = MemRead_in | MemWrite_in;

  ls_align u_align (
    .func3      (func3_in),
    .store      (MemWrite_in),
    .addr       (alu_in[1:0]),
    .rs2        (reg2_data_in),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_ext   (load_ext),
    .misaligned (misaligned)
  );

  always_comb begin
    req_raw = 1'b0;
    timeout = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        req_raw = memop & ~misaligned;
        if (req_raw && !dmem_ack) begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!dmem_ack && cnt == CNT_W'(TIMEOUT_CYC)) begin
          timeout = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          req_raw = 1'b1;
          if (dmem_ack) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Reset must kill an in-flight request without waiting for a clock edge.
  assign dmem_req       = req_raw & ~res;
  assign dmem_we        = MemWrite_in;
  assign dmem_addr      = {alu_in[31:2], 2'b00};
  assign stall_out      = dmem_req & ~dmem_ack;
  assign PCSrc_out      = Branch_in & zero_in & ~stall_out;
  assign branch_tgt_out = pc_in;

  assign mis_drop = memop & misaligned & (state == S_IDLE);

  always_comb begin
    memwb_n.reg_write = RegWrite_in & ~stall_out & ~mis_drop & ~timeout;
    memwb_n.rd        = rd_in;
    memwb_n.wb_data   = MemtoReg_in ? load_ext : alu_in;
    memwb_n.misalign  = mis_drop;
    memwb_n.bus_err   = timeout;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) memwb <= '0;
    else     memwb <= memwb_n;
  end

  assign RegWrite_out = memwb.reg_write;
  assign rd_out       = memwb.rd;
  assign wb_data_out  = memwb.wb_data;
  assign misalign_out = memwb.misalign;
  assign bus_err_out  = memwb.bus_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a queue of expected MEM/WB results.
module tb_mem_wb_stage;

  logic        clk, res;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, zero_in;
  logic [31:0] pc_in, alu_in, reg2_data_in, dmem_rdata;
  logic [2:0]  func3_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, dmem_ack, stall_out, PCSrc_out;
  logic [31:0] dmem_addr, dmem_wdata, branch_tgt_out, wb_data_out;
  logic [3:0]  dmem_be;
  logic        RegWrite_out, misalign_out, bus_err_out;
  logic [4:0]  rd_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        err;
  } exp_t;
  exp_t sb[$];

  mem_wb_stage #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk), .res(res),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .Branch_in(Branch_in), .zero_in(zero_in), .pc_in(pc_in),
    .func3_in(func3_in), .alu_in(alu_in), .reg2_data_in(reg2_data_in), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .PCSrc_out(PCSrc_out), .branch_tgt_out(branch_tgt_out),
    .RegWrite_out(RegWrite_out), .rd_out(rd_out), .wb_data_out(wb_data_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    Branch_in = 0; zero_in = 0; pc_in = 0; func3_in = 0; alu_in = 0;
    reg2_data_in = 0; rd_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic set_op(input logic rd_op, input logic wr_op, input logic rw, input logic m2r,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd);
    idle();
    MemRead_in = rd_op; MemWrite_in = wr_op; RegWrite_in = rw; MemtoReg_in = m2r;
    func3_in = f3; alu_in = a; reg2_data_in = d; rd_in = rd;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] data,
                          input logic cd, input logic mis, input logic err);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.chk_data = cd; e.mis = mis; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_we"},  RegWrite_out, e.we);
      chk({tag, "_rd"},  rd_out,       e.rd);
      if (e.chk_data) chk({tag, "_data"}, wb_data_out, e.data);
      chk({tag, "_mis"}, misalign_out, e.mis);
      chk({tag, "_err"}, bus_err_out,  e.err);
    end
  endtask

  logic [2:0]  lf3 [7];
  logic [31:0] la  [7];
  logic [31:0] lrd [7];
  logic [31:0] lex [7];
  logic [2:0]  sf3 [4];
  logic [31:0] sa  [4];
  logic [31:0] sd  [4];
  logic [3:0]  sbe [4];
  logic [31:0] swd [4];

  initial begin
    int stalls;
    logic done;

    lf3[0] = 3'b101; la[0] = 32'h102; lrd[0] = 32'hBEEF1234; lex[0] = 32'h0000BEEF;
    lf3[1] = 3'b000; la[1] = 32'h100; lrd[1] = 32'h0000007F; lex[1] = 32'h0000007F;
    lf3[2] = 3'b001; la[2] = 32'h000; lrd[2] = 32'h00008001; lex[2] = 32'hFFFF8001;
    lf3[3] = 3'b100; la[3] = 32'h101; lrd[3] = 32'h0000AB00; lex[3] = 32'h000000AB;
    lf3[4] = 3'b001; la[4] = 32'h102; lrd[4] = 32'h7FFF0000; lex[4] = 32'h00007FFF;
    lf3[5] = 3'b011; la[5] = 32'h104; lrd[5] = 32'hCAFEF00D; lex[5] = 32'hCAFEF00D;
    lf3[6] = 3'b010; la[6] = 32'h108; lrd[6] = 32'h12345678; lex[6] = 32'h12345678;

    sf3[0] = 3'b001; sa[0] = 32'h102; sd[0] = 32'h000000AB; sbe[0] = 4'b1100; swd[0] = 32'h00AB00AB;
    sf3[1] = 3'b000; sa[1] = 32'h101; sd[1] = 32'h00000012; sbe[1] = 4'b0010; swd[1] = 32'h12121212;
    sf3[2] = 3'b000; sa[2] = 32'h103; sd[2] = 32'hFFFFFF3C; sbe[2] = 4'b1000; swd[2] = 32'h3C3C3C3C;
    sf3[3] = 3'b111; sa[3] = 32'h10C; sd[3] = 32'h01020304; sbe[3] = 4'b1111; swd[3] = 32'h01020304;

    // Reset state
    res = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", RegWrite_out, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_data", wb_data_out, 0);
    chk("rst_mis", misalign_out, 0);
    chk("rst_err", bus_err_out, 0);
    chk("rst_req", dmem_req, 0);
    res = 1'b0;

    // SW zero-wait
    set_op(0, 1, 0, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0);
    dmem_ack = 1;
    push_exp(0, 0, 32'h100, 1, 0, 0);
    @(negedge clk);
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_be", dmem_be, 4'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall", stall_out, 0);
    tick();
    wb_check("sw");

    // LB with three wait cycles
    set_op(1, 0, 1, 1, 3'b000, 32'h103, 0, 5);
    dmem_rdata = 32'h80123456;
    push_exp(1, 5, 32'hFFFFFF80, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lb_stall", stall_out, 1);
      chk("lb_req", dmem_req, 1);
      tick();
      chk("lb_bubble", RegWrite_out, 0);
    end
    dmem_ack = 1;
    @(negedge clk);
    chk("lb_stall_ack", stall_out, 0);
    chk("lb_addr", dmem_addr, 32'h100);
    tick();
    wb_check("lb");
    idle();
    tick();
    chk("lb_we_once", RegWrite_out, 0);

    // Load extraction table, zero-wait
    for (int i = 0; i < 7; i++) begin
      set_op(1, 0, 1, 1, lf3[i], la[i], 0, 5'(i + 10));
      dmem_rdata = lrd[i];
      dmem_ack = 1;
      push_exp(1, 5'(i + 10), lex[i], 1, 0, 0);
      @(negedge clk);
      chk("ld_be", dmem_be, 4'hF);
      chk("ld_we", dmem_we, 0);
      chk("ld_addr", dmem_addr, {la[i][31:2], 2'b00});
      chk("ld_stall", stall_out, 0);
      tick();
      wb_check("ld");
    end

    // Store lane table, zero-wait
    for (int i = 0; i < 4; i++) begin
      set_op(0, 1, 0, 0, sf3[i], sa[i], sd[i], 0);
      dmem_ack = 1;
      push_exp(0, 0, sa[i], 1, 0, 0);
      @(negedge clk);
      chk("st_req", dmem_req, 1);
      chk("st_be", dmem_be, sbe[i]);
      chk("st_wdata", dmem_wdata, swd[i]);
      tick();
      wb_check("st");
    end

    // Plain ALU result
    set_op(0, 0, 1, 0, 0, 32'h1234, 0, 7);
    push_exp(1, 7, 32'h1234, 1, 0, 0);
    @(negedge clk);
    chk("alu_req", dmem_req, 0);
    tick();
    wb_check("alu");

    // Misaligned LW and SH
    set_op(1, 0, 1, 1, 3'b010, 32'h101, 0, 3);
    push_exp(0, 3, 0, 0, 1, 0);
    @(negedge clk);
    chk("mis_lw_req", dmem_req, 0);
    chk("mis_lw_stall", stall_out, 0);
    tick();
    wb_check("mis_lw");
    set_op(0, 1, 0, 0, 3'b001, 32'h103, 32'h55, 0);
    push_exp(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("mis_sh_req", dmem_req, 0);
    tick();
    wb_check("mis_sh");
    idle();
    tick();
    chk("mis_pulse", misalign_out, 0);

    // Branch resolve
    idle();
    Branch_in = 1; zero_in = 1; pc_in = 32'h40;
    #1;
    chk("br_pcsrc", PCSrc_out, 1);
    chk("br_tgt", branch_tgt_out, 32'h40);
    zero_in = 0;
    #1;
    chk("br_nz", PCSrc_out, 0);
    tick();

    // Timeout: never ack
    set_op(1, 0, 1, 1, 3'b010, 32'h200, 0, 9);
    push_exp(0, 9, 0, 0, 0, 1);
    stalls = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall_out) begin
        stalls++;
        tick();
      end else begin
        done = 1;
        chk("to_req_drop", dmem_req, 0);
      end
    end
    chk("to_done", done, 1);
    chk("to_stalls", stalls, 16);
    tick();
    wb_check("to");
    idle();
    tick();
    chk("to_pulse", bus_err_out, 0);

    // Reset while waiting
    set_op(1, 0, 1, 1, 3'b010, 32'h300, 0, 4);
    tick();
    tick();
    @(negedge clk);
    chk("rw_stall_pre", stall_out, 1);
    #1 res = 1'b1;
    #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_stall", stall_out, 0);
    tick();
    res = 1'b0;
    idle();
    @(negedge clk);
    chk("rw_idle_req", dmem_req, 0);
    chk("rw_we", RegWrite_out, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
